// File: rtl/if_mod.sv
// Dual-issue instruction fetch stage: one PC register, two fetch slots.
// Optional macro IF_MOD_BRANCH1_EN enables the younger redirect port.
module if_mod (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_mem_take_branch0,
  input  logic        ex_mem_take_branch1,
  input  logic [63:0] ex_mem_target_pc0,
  input  logic [63:0] ex_mem_target_pc1,
  input  logic [63:0] Imem2proc_data,
  input  logic [1:0]  Imem_valid,
  input  logic [1:0]  busy,
  output logic [63:0] proc2Imem_addr,
  output logic [63:0] if_NPC_out,
  output logic [31:0] if_IR_out0,
  output logic [31:0] if_IR_out1,
  output logic        if_valid_inst_out0,
  output logic        if_valid_inst_out1
);

  localparam logic [31:0] NOP = 32'h47ff041f;

  logic [63:0] r_pc;
  logic [1:0]  w_cap;
  logic        w_redir;
  logic [63:0] w_tgt;
  logic        w_v0;
  logic        w_v1;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [63:0] w_inc;

`ifdef IF_MOD_BRANCH1_EN
  assign w_redir = ex_mem_take_branch0 | ex_mem_take_branch1;
  assign w_tgt   = ex_mem_take_branch0 ? ex_mem_target_pc0
                                       : ex_mem_target_pc1;
`else
  logic w_unused;
  assign w_unused = ^{ex_mem_take_branch1, ex_mem_target_pc1};
  assign w_redir  = ex_mem_take_branch0;
  assign w_tgt    = ex_mem_target_pc0;
`endif

  // Free slots downstream: 2, 1 or none.
  always_comb begin
    w_cap = 2'd0;
    unique case (busy)
      2'd0:    w_cap = 2'd2;
      2'd1:    w_cap = 2'd1;
      default: w_cap = 2'd0;
    endcase
  end

  // Slot selection; a redirect or active reset squashes both slots.
  always_comb begin
    w_v0 = 1'b0;
    w_v1 = 1'b0;
    w_w0 = Imem2proc_data[31:0];
    w_w1 = Imem2proc_data[63:32];
    if (!r_pc[2]) begin
      w_v0 = Imem_valid[0] && (w_cap != 2'd0);
      w_v1 = w_v0 && Imem_valid[1] && (w_cap == 2'd2);
    end else begin
      w_w0 = Imem2proc_data[63:32];
      w_v0 = Imem_valid[1] && (w_cap != 2'd0);
    end
    if (w_redir || !reset) begin
      w_v0 = 1'b0;
      w_v1 = 1'b0;
    end
  end

  assign w_inc = {61'd0, w_v0 & w_v1, w_v0 ^ w_v1, 2'b00};

  assign proc2Imem_addr     = {r_pc[63:3], 3'b000};
  assign if_NPC_out         = r_pc + w_inc;
  assign if_valid_inst_out0 = w_v0;
  assign if_valid_inst_out1 = w_v1;
  assign if_IR_out0         = w_v0 ? w_w0 : NOP;
  assign if_IR_out1         = w_v1 ? w_w1 : NOP;

  // PC: redirect target, else advance by the number of issued words.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_pc <= 64'd0;
    else if (w_redir)
      r_pc <= {w_tgt[63:2], 2'b00};
    else
      r_pc <= if_NPC_out;
  end

endmodule

// File: tb/tb_if_mod.sv
// Directed-vector bench for if_mod.
// Expected values follow IF_MOD_BRANCH1_EN if defined.
module tb_if_mod;

  localparam logic [31:0] NOP = 32'h47ff041f;
  localparam logic [63:0] D1  = 64'h0123456789abcdef;
  localparam logic [63:0] D2  = 64'hdeadbeefcafef00d;

  logic        clock;
  logic        reset;
  logic        b0, b1;
  logic [63:0] t0, t1;
  logic [63:0] data;
  logic [1:0]  iv;
  logic [1:0]  busy;
  logic [63:0] addr, npc;
  logic [31:0] ir0, ir1;
  logic        v0, v1;

  int n_err;
  int n_chk;

  if_mod dut (
    .clock               (clock),
    .reset               (reset),
    .ex_mem_take_branch0 (b0),
    .ex_mem_take_branch1 (b1),
    .ex_mem_target_pc0   (t0),
    .ex_mem_target_pc1   (t1),
    .Imem2proc_data      (data),
    .Imem_valid          (iv),
    .busy                (busy),
    .proc2Imem_addr      (addr),
    .if_NPC_out          (npc),
    .if_IR_out0          (ir0),
    .if_IR_out1          (ir1),
    .if_valid_inst_out0  (v0),
    .if_valid_inst_out1  (v1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  busy;
    logic [1:0]  iv;
    logic [63:0] data;
    logic        b0;
    logic        b1;
    logic [63:0] t0;
    logic [63:0] t1;
    logic [63:0] addr;
    logic [31:0] ir0;
    logic [31:0] ir1;
    logic        v0;
    logic        v1;
    logic [63:0] npc;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(
    logic [1:0] bz, logic [1:0] ivv, logic [63:0] d,
    logic br0, logic br1, logic [63:0] tg0, logic [63:0] tg1,
    logic [63:0] ea, logic [31:0] e0, logic [31:0] e1,
    logic ev0, logic ev1, logic [63:0] en);
    vec_t v;
    v.busy = bz;  v.iv = ivv;  v.data = d;
    v.b0 = br0;   v.b1 = br1;  v.t0 = tg0;  v.t1 = tg1;
    v.addr = ea;  v.ir0 = e0;  v.ir1 = e1;
    v.v0 = ev0;   v.v1 = ev1;  v.npc = en;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [63:0] ea,
                         logic [31:0] e0, logic [31:0] e1,
                         logic ev0, logic ev1, logic [63:0] en);
    chk({tag, ".addr"}, addr, ea);
    chk({tag, ".ir0"}, {32'd0, ir0}, {32'd0, e0});
    chk({tag, ".ir1"}, {32'd0, ir1}, {32'd0, e1});
    chk({tag, ".v0"}, {63'd0, v0}, {63'd0, ev0});
    chk({tag, ".v1"}, {63'd0, v1}, {63'd0, ev1});
    chk({tag, ".npc"}, npc, en);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    reset = 1'b0;
    b0 = 0; b1 = 0; t0 = '0; t1 = '0;
    data = D1; iv = 2'd3; busy = 2'd2;

    tv[0]  = mk(0, 3, D1, 0, 0, 0, 0,
                64'h0, 32'h89abcdef, 32'h01234567, 1, 1, 64'h8);
    tv[1]  = mk(1, 3, D1, 0, 0, 0, 0,
                64'h8, 32'h89abcdef, NOP, 1, 0, 64'hc);
    tv[2]  = mk(0, 3, D1, 0, 0, 0, 0,
                64'h8, 32'h01234567, NOP, 1, 0, 64'h10);
    tv[3]  = mk(2, 3, D1, 0, 0, 0, 0,
                64'h10, NOP, NOP, 0, 0, 64'h10);
    tv[4]  = mk(3, 3, D1, 0, 0, 0, 0,
                64'h10, NOP, NOP, 0, 0, 64'h10);
    tv[5]  = mk(2, 3, D1, 0, 0, 0, 0,
                64'h10, NOP, NOP, 0, 0, 64'h10);
    tv[6]  = mk(0, 2, D1, 0, 0, 0, 0,
                64'h10, NOP, NOP, 0, 0, 64'h10);
    tv[7]  = mk(0, 1, D2, 0, 0, 0, 0,
                64'h10, 32'hcafef00d, NOP, 1, 0, 64'h14);
    tv[8]  = mk(1, 1, D2, 0, 0, 0, 0,
                64'h10, NOP, NOP, 0, 0, 64'h14);
    tv[9]  = mk(0, 3, D2, 1, 1, 64'h100, 64'h200,
                64'h10, NOP, NOP, 0, 0, 64'h14);
    tv[10] = mk(0, 3, D2, 0, 0, 0, 0,
                64'h100, 32'hcafef00d, 32'hdeadbeef, 1, 1, 64'h108);
    tv[11] = mk(0, 3, D2, 1, 0, 64'hfffffffffffffff8, 0,
                64'h108, NOP, NOP, 0, 0, 64'h108);
    tv[12] = mk(0, 3, D1, 0, 0, 0, 0,
                64'hfffffffffffffff8, 32'h89abcdef, 32'h01234567,
                1, 1, 64'h0);
    tv[13] = mk(0, 3, D1, 0, 0, 0, 0,
                64'h0, 32'h89abcdef, 32'h01234567, 1, 1, 64'h8);
`ifdef IF_MOD_BRANCH1_EN
    tv[14] = mk(0, 3, D2, 0, 1, 64'h300, 64'h204,
                64'h8, NOP, NOP, 0, 0, 64'h8);
    tv[15] = mk(0, 3, D2, 0, 0, 0, 0,
                64'h200, 32'hdeadbeef, NOP, 1, 0, 64'h208);
`else
    tv[14] = mk(0, 3, D2, 0, 1, 64'h300, 64'h204,
                64'h8, 32'hcafef00d, 32'hdeadbeef, 1, 1, 64'h10);
    tv[15] = mk(0, 3, D2, 0, 0, 0, 0,
                64'h10, 32'hcafef00d, 32'hdeadbeef, 1, 1, 64'h18);
`endif

    #2;
    chk_all("rst_b2", 64'h0, NOP, NOP, 0, 0, 64'h0);
    busy = 2'd0;
    #1;
    chk_all("rst_b0", 64'h0, NOP, NOP, 0, 0, 64'h0);
    busy = 2'd2;
    @(posedge clock);
    #1;
    chk("rst_edge.addr", addr, 64'h0);
    reset = 1'b1;
    #3;
    chk_all("rel", 64'h0, NOP, NOP, 0, 0, 64'h0);
    @(posedge clock);
    #1;
    chk("rel_hold.addr", addr, 64'h0);
    chk("rel_hold.npc", npc, 64'h0);

    for (int i = 0; i < 16; i++) begin
      busy = tv[i].busy;
      iv   = tv[i].iv;
      data = tv[i].data;
      b0   = tv[i].b0;
      b1   = tv[i].b1;
      t0   = tv[i].t0;
      t1   = tv[i].t1;
      #3;
      chk_all($sformatf("v%0d", i), tv[i].addr, tv[i].ir0,
              tv[i].ir1, tv[i].v0, tv[i].v1, tv[i].npc);
      @(posedge clock);
      #1;
    end

    b0 = 0; b1 = 0; busy = 2'd0; iv = 2'd3; data = D1;
    #3;
`ifdef IF_MOD_BRANCH1_EN
    chk("pre_rst.addr", addr, 64'h208);
`else
    chk("pre_rst.addr", addr, 64'h18);
`endif
    reset = 1'b0;
    #1;
    chk_all("async_rst", 64'h0, NOP, NOP, 0, 0, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_all("refetch", 64'h0, 32'h89abcdef, 32'h01234567,
            1, 1, 64'h8);
    @(posedge clock);
    #1;
    chk("refetch_next.addr", addr, 64'h8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
